// File: rtl/gumnut_pkg.sv
// Shared types and defaults for the Gumnut PC / return-context unit.
package gumnut_pkg;

  localparam int PC_W = 12;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic {
    RUN = 1'b0,
    ISR = 1'b1
  } state_t;

  localparam pc_t DEF_RESET_PC   = 12'h000;
  localparam pc_t DEF_INT_VECTOR = 12'h001;

endpackage

// File: rtl/return_stack.sv
// Parameterized return-address LIFO with sticky error on overflow, underflow or push/pop conflict.
module return_stack #(
  parameter int                W         = 12,
  parameter int                DEPTH     = 8,
  parameter logic [W-1:0]      EMPTY_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         err
);
  import gumnut_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   count;
  logic [AW:0]   count_n;
  logic          err_n;
  logic          do_push;
  logic [AW-1:0] rd_idx;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  // Low bits wrap to DEPTH-1 when the stack is full, so this stays in range.
  assign rd_idx = count[AW-1:0] - AW'(1);
  assign top    = empty ? EMPTY_VAL : mem[rd_idx];

  // Next occupancy and error flag from the gated push/pop requests.
  always_comb begin
    count_n = count;
    err_n   = err;
    do_push = 1'b0;
    if (push && pop) begin
      err_n = 1'b1;
    end else if (push) begin
      if (full) begin
        err_n = 1'b1;
      end else begin
        do_push = 1'b1;
        count_n = count + (AW+1)'(1);
      end
    end else if (pop) begin
      if (empty) begin
        err_n = 1'b1;
      end else begin
        count_n = count - (AW+1)'(1);
      end
    end else begin
      count_n = count;
    end
  end

  // Occupancy and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_n;
      err   <= err_n;
    end
  end

  // Storage is unobservable while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_return_unit.sv
// Gumnut program counter, interrupt entry/exit context and return-stack wrapper.
module pc_return_unit
  import gumnut_pkg::*;
#(
  parameter int                PC_W       = gumnut_pkg::PC_W,
  parameter int                DEPTH      = 8,
  parameter logic [PC_W-1:0]   RESET_PC   = DEF_RESET_PC,
  parameter logic [PC_W-1:0]   INT_VECTOR = DEF_INT_VECTOR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_en_i,
  input  logic [PC_W-1:0] next_pc_i,
  input  logic            jsb_i,
  input  logic            ret_i,
  input  logic            reti_i,
  input  logic            enai_i,
  input  logic            disi_i,
  input  logic            int_req_i,
  input  logic            carry_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] stackaddr_o,
  output logic [PC_W-1:0] intpc_o,
  output logic            int_ack_o,
  output logic            restore_flags_o,
  output logic            carry_o,
  output logic            zero_o,
  output logic            stack_full_o,
  output logic            stack_empty_o,
  output logic            stack_err_o
);

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] intpc, intpc_n;
  logic            ie, ie_n;
  logic            carry, carry_n;
  logic            zero, zero_n;
  logic            ack, ack_n;
  logic            restore, restore_n;
  logic            take;

  return_stack #(
    .W         (PC_W),
    .DEPTH     (DEPTH),
    .EMPTY_VAL (RESET_PC)
  ) u_stack (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (pc_en_i & jsb_i),
    .pop   (pc_en_i & ret_i),
    .din   (pc + PC_W'(1)),
    .top   (stackaddr_o),
    .full  (stack_full_o),
    .empty (stack_empty_o),
    .err   (stack_err_o)
  );

  // Boundary decisions: PC, interrupt entry/exit, enable flag and pulses.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    intpc_n   = intpc;
    ie_n      = ie;
    carry_n   = carry;
    zero_n    = zero;
    ack_n     = 1'b0;
    restore_n = 1'b0;
    take      = 1'b0;
    if (pc_en_i) begin
      take = (state == RUN) && ie && int_req_i && !reti_i;
      pc_n = take ? INT_VECTOR : next_pc_i;
      case (state)
        RUN: begin
          if (take) begin
            state_n = ISR;
            intpc_n = next_pc_i;
            carry_n = carry_i;
            zero_n  = zero_i;
          end else begin
            state_n = RUN;
          end
        end
        ISR: begin
          if (reti_i) begin
            state_n   = RUN;
            restore_n = 1'b1;
          end else begin
            state_n = ISR;
          end
        end
        default: state_n = RUN;
      endcase
      // Entry beats disi, disi beats enai, explicit requests beat the reti re-enable.
      if (take) begin
        ie_n = 1'b0;
      end else if (disi_i) begin
        ie_n = 1'b0;
      end else if (enai_i) begin
        ie_n = 1'b1;
      end else if ((state == ISR) && reti_i) begin
        ie_n = 1'b1;
      end else begin
        ie_n = ie;
      end
      ack_n = take;
    end else begin
      state_n = state;
    end
  end

  // Architectural state and registered pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= RUN;
      pc      <= RESET_PC;
      intpc   <= RESET_PC;
      ie      <= 1'b0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      ack     <= 1'b0;
      restore <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      intpc   <= intpc_n;
      ie      <= ie_n;
      carry   <= carry_n;
      zero    <= zero_n;
      ack     <= ack_n;
      restore <= restore_n;
    end
  end

  assign pc_o            = pc;
  assign intpc_o         = intpc;
  assign int_ack_o       = ack;
  assign restore_flags_o = restore;
  assign carry_o         = carry;
  assign zero_o          = zero;

endmodule

// File: tb/tb_pc_return_unit.sv
// Self-checking bench for pc_return_unit: directed test-plan sequences plus randomized traffic vs a behavioural model.
module tb_pc_return_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [11:0] nxt = 12'h000;
  logic        jsb = 1'b0, ret = 1'b0, reti = 1'b0, enai = 1'b0, disi = 1'b0, req = 1'b0;
  logic        cin = 1'b0, zin = 1'b0;
  logic [11:0] pc, saddr, ipc;
  logic        ack, rest, cout, zout, full, empty, err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  int m_pc, m_intpc, m_cnt;
  int m_stack [8];
  bit m_c, m_z, m_ie, m_isr, m_ack, m_rest, m_err;

  pc_return_unit dut (
    .clk_i(clk), .rst_i(rst), .pc_en_i(en), .next_pc_i(nxt),
    .jsb_i(jsb), .ret_i(ret), .reti_i(reti), .enai_i(enai), .disi_i(disi),
    .int_req_i(req), .carry_i(cin), .zero_i(zin),
    .pc_o(pc), .stackaddr_o(saddr), .intpc_o(ipc), .int_ack_o(ack),
    .restore_flags_o(rest), .carry_o(cout), .zero_o(zout),
    .stack_full_o(full), .stack_empty_o(empty), .stack_err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_top();
    return (m_cnt == 0) ? 0 : m_stack[m_cnt-1];
  endfunction

  task automatic model_reset();
    m_pc = 0; m_intpc = 0; m_cnt = 0;
    m_c = 0; m_z = 0; m_ie = 0; m_isr = 0; m_ack = 0; m_rest = 0; m_err = 0;
  endtask

  // Applies one rising edge of the specified behaviour to the model.
  task automatic model_update();
    bit take, old_isr;
    if (!en) begin
      m_ack = 0; m_rest = 0;
      return;
    end
    old_isr = m_isr;
    take = !m_isr && m_ie && req && !reti;
    if (jsb && ret) m_err = 1;
    else if (jsb) begin
      if (m_cnt == 8) m_err = 1;
      else begin m_stack[m_cnt] = (m_pc + 1) % 4096; m_cnt++; end
    end else if (ret) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt--;
    end
    m_pc = take ? 1 : int'(nxt);
    if (take) m_ie = 0;
    else if (disi) m_ie = 0;
    else if (enai) m_ie = 1;
    else if (old_isr && reti) m_ie = 1;
    if (take) begin
      m_intpc = int'(nxt); m_c = cin; m_z = zin; m_isr = 1;
    end else if (old_isr && reti) m_isr = 0;
    m_ack = take;
    m_rest = old_isr && reti;
  endtask

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc", pc, m_pc);
      check("stackaddr", saddr, model_top());
      check("intpc", ipc, m_intpc);
      check("int_ack", ack, m_ack);
      check("restore", rest, m_rest);
      check("carry", cout, m_c);
      check("zero", zout, m_z);
      check("full", full, m_cnt == 8);
      check("empty", empty, m_cnt == 0);
      check("err", err, m_err);
    end
  end

  task automatic step(bit e, logic [11:0] n, bit j, bit r, bit ri,
                      bit ea, bit di, bit rq, bit c, bit z);
    en = e; nxt = n; jsb = j; ret = r; reti = ri; enai = ea; disi = di;
    req = rq; cin = c; zin = z;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    en = 0; jsb = 0; ret = 0; reti = 0; enai = 0; disi = 0; req = 0;
  endtask

  // Asynchronous reset away from any clock edge, checked immediately.
  task automatic do_reset(bit lit);
    idle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    if (lit) begin
      check("rst_pc", pc, 32'h000);
      check("rst_empty", empty, 1);
      check("rst_err", err, 0);
      check("rst_stackaddr", saddr, 32'h000);
      check("rst_intpc", ipc, 32'h000);
      check("rst_full", full, 0);
      check("rst_ack", ack, 0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset(1);
    cmp_en = 1'b1;

    // jsb / ret round trip
    step(1, 12'h010, 0,0,0,0,0,0,0,0);
    check("setup_pc", pc, 32'h010);
    step(1, 12'h200, 1,0,0,0,0,0,0,0);
    check("jsb_pc", pc, 32'h200);
    check("jsb_top", saddr, 32'h011);
    step(1, 12'h011, 0,1,0,0,0,0,0,0);
    check("ret_pc", pc, 32'h011);
    check("ret_empty", empty, 1);

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) step(1, 12'h100 + 12'(i), 1,0,0,0,0,0,0,0);
    check("fill_full", full, 1);
    check("fill_err", err, 0);
    check("fill_top", saddr, 32'h107);
    step(1, 12'h108, 1,0,0,0,0,0,0,0);
    check("ovf_err", err, 1);
    check("ovf_top", saddr, 32'h107);
    for (int i = 0; i < 9; i++) step(1, 12'h300, 0,1,0,0,0,0,0,0);
    check("drain_top", saddr, 32'h000);
    check("drain_empty", empty, 1);

    // Interrupt entry / exit with flag save and restore
    do_reset(1);
    step(1, 12'h020, 0,0,0,1,0,0,0,0);
    step(1, 12'h055, 0,0,0,0,0,1,1,0);
    check("int_pc", pc, 32'h001);
    check("int_intpc", ipc, 32'h055);
    check("int_ack", ack, 1);
    step(1, 12'h002, 0,0,0,0,0,1,0,0);
    check("nonest_ack", ack, 0);
    check("nonest_pc", pc, 32'h002);
    step(1, 12'h055, 0,0,1,0,0,0,0,1);
    check("reti_pc", pc, 32'h055);
    check("reti_restore", rest, 1);
    check("reti_carry", cout, 1);
    check("reti_zero", zout, 0);
    step(1, 12'h056, 0,0,0,0,0,0,0,0);
    check("restore_pulse_end", rest, 0);
    step(1, 12'h057, 0,0,0,0,0,1,0,1);
    check("reenabled_ack", ack, 1);
    check("reenabled_pc", pc, 32'h001);
    step(1, 12'h057, 0,0,1,0,0,0,0,0);
    step(1, 12'h060, 0,0,0,0,1,0,0,0);
    step(1, 12'h070, 0,0,0,0,0,1,0,0);
    check("masked_pc", pc, 32'h070);
    check("masked_ack", ack, 0);

    // Reset while inside the ISR
    step(1, 12'h080, 0,0,0,1,0,0,0,0);
    step(1, 12'h090, 1,0,0,0,0,1,1,1);
    check("isr_entry_pc", pc, 32'h001);
    do_reset(1);

    // Push/pop conflict and disabled boundary
    step(1, 12'h030, 1,1,0,0,0,0,0,0);
    check("conflict_empty", empty, 1);
    check("conflict_err", err, 1);
    step(0, 12'h0FF, 1,1,1,1,1,1,1,1);
    check("hold_pc", pc, 32'h030);
    check("hold_ack", ack, 0);
    check("hold_empty", empty, 1);

    // Randomized traffic
    do_reset(0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset(0);
      step($urandom_range(0, 9) < 8, 12'($urandom),
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3,
           1'($urandom), 1'($urandom));
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_return_unit.md
# pc_return_unit

Program-counter register and return-address/interrupt context unit for the Gumnut core. It holds the architectural PC, consumes the next-PC value chosen by the new-PC selector, and sources the two return targets that selector consumes: top-of-stack for `ret` and saved interrupt PC for `reti`. It also owns the return-address LIFO, the interrupt-enable flag, single-level interrupt entry/exit, and flag save/restore across interrupts.

## Interface
- `PC_W`, 12, PC / address width
- `DEPTH`, 8, return-stack entries (power of two, ≥2)
- `RESET_PC`, 12'h000, PC after reset
- `INT_VECTOR`, 12'h001, PC loaded on interrupt entry
- `clk_i`  in  1  core clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `pc_en_i`  in  1  instruction boundary strobe; all updates happen only when high
- `next_pc_i`  in  PC_W  next PC from selector
- `jsb_i`  in  1  current instruction is `jsb` (push return address)
- `ret_i`  in  1  current instruction is `ret` (pop)
- `reti_i`  in  1  current instruction is `reti`
- `enai_i` / `disi_i`  in  1 each  set / clear interrupt enable
- `int_req_i`  in  1  level interrupt request
- `carry_i`, `zero_i`  in  1 each  live ALU flags
- `pc_o`  out  PC_W  current PC
- `stackaddr_o`  out  PC_W  top-of-stack entry (RESET_PC when empty)
- `intpc_o`  out  PC_W  saved interrupt return PC
- `int_ack_o`  out  1  one-cycle pulse, interrupt taken
- `restore_flags_o`  out  1  one-cycle pulse, load `carry_o`/`zero_o` into flag regs
- `carry_o`, `zero_o`  out  1 each  saved flags
- `stack_full_o`, `stack_empty_o`  out  1 each  LIFO status
- `stack_err_o`  out  1  sticky overflow/underflow/conflict flag

## Operation
- FSM states: RUN, ISR. Reset → RUN.
- `pc_en_i` low: no state changes at all; pulses deassert.
- Boundary in RUN, no interrupt taken: `pc_o <= next_pc_i`.
- `jsb_i`: push `pc_o + 1` (mod 2^PC_W). Full: push dropped, `stack_err_o` set, contents unchanged.
- `ret_i`: pop. Empty: pointer unchanged, `stack_err_o` set; `stackaddr_o` reads RESET_PC.
- `jsb_i` and `ret_i` both high: neither executes; `stack_err_o` set.
- Interrupt taken when state RUN, IE=1, `int_req_i`=1, `pc_en_i`=1, `reti_i`=0. The current instruction's stack effect still executes. `intpc <= next_pc_i`, saved flags `<= {carry_i, zero_i}`, `pc_o <= INT_VECTOR`, IE cleared, state → ISR, `int_ack_o` pulses next cycle.
- ISR: no nesting; `int_req_i` ignored until exit. Boundary with `reti_i`: `pc_o <= next_pc_i` (selector supplies `intpc_o`), IE set, state → RUN, `restore_flags_o` pulses next cycle.
- `reti_i` in RUN: treated as no-op for state/IE; PC still follows `next_pc_i`.
- `enai_i`/`disi_i` at boundary set/clear IE; `disi_i` wins if both; `enai_i` in the same boundary as interrupt entry loses (IE ends 0).
- `stack_err_o` clears only on reset.

## Timing
- Reset values: `pc_o`=RESET_PC, stack empty, `stackaddr_o`=RESET_PC, `intpc_o`=RESET_PC, `carry_o`=`zero_o`=0, IE=0, `int_ack_o`=`restore_flags_o`=0, `stack_full_o`=0, `stack_empty_o`=1, `stack_err_o`=0.
- All state registered on `clk_i` rising edge; reset takes effect immediately, mid-ISR or mid-push included.
- `stackaddr_o`, `intpc_o`, status flags: functions of registered state only, valid in the same cycle as `pc_o` (zero-latency read path to selector; no input→output combinational path).
- Push/pop visible on `stackaddr_o` the cycle after the boundary.
- Pulses are exactly one cycle, registered.

## Structure
- `gumnut_pkg`: `PC_W`, `pc_t` typedef, FSM state enum, RESET_PC/INT_VECTOR defaults.
- Sub-module `return_stack`: parameterized LIFO (push, pop, top, full, empty, err); top unit holds PC, IE, FSM, interrupt context.

## Test plan
- Reset mid-run: `pc_o`=0x000, empty=1, err=0, IE=0 immediately on `rst_i`.
- `pc_o`=0x010, `jsb_i`, `next_pc_i`=0x200 → `pc_o`=0x200, `stackaddr_o`=0x011; then `ret_i`, `next_pc_i`=0x011 → `pc_o`=0x011, empty=1.
- 8 pushes → full=1, err=0; 9th push → err=1, top unchanged; 9 pops → 9th sets nothing new, `stackaddr_o`=0x000.
- IE=1, `int_req_i`=1 at boundary, `next_pc_i`=0x055, carry=1, zero=0 → `pc_o`=0x001, `intpc_o`=0x055, `int_ack_o` one pulse; `reti_i` with `next_pc_i`=0x055 → `pc_o`=0x055, `restore_flags_o` pulse, `carry_o`=1, `zero_o`=0, IE=1.
- `int_req_i` held in ISR → no second `int_ack_o`; request with IE=0 → ignored.
- `jsb_i`+`ret_i` together → stack unchanged, `stack_err_o`=1; `pc_en_i`=0 with all controls high → nothing changes.
